// File: rtl/lif_serial_subtractor.sv
// lif_serial_subtractor
//   Bit-serial, LSB-first unsigned subtractor (a - b) for the LIF neuron
//   datapath. It applies leak and post-spike reset offsets to the membrane
//   potential. Operands are latched when a start is accepted. One bit is
//   processed per clock. The result and borrow are presented with a
//   one-cycle done pulse.
//
// Parameters
//   WIDTH    operand/result width (>= 2)
//   SATURATE 1: clamp the result to 0 on underflow; 0: modulo-2^WIDTH wrap
//
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   request, sampled only while busy=0
//   a, b    minuend / subtrahend, unsigned
//   busy    operation in progress
//   done    one-cycle completion pulse
//   diff    result, held until the next completion
//   borrow  1 when a < b, held with diff
module lif_serial_subtractor #(
  parameter int WIDTH    = 10,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a_sr, r_b_sr, r_res, r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_bw, r_borrow, r_done;

  logic             w_d, w_bw_nxt, w_last;
  logic [WIDTH-1:0] w_res_nxt;

  // Full-subtractor slice on the current LSBs.
  assign w_d       = r_a_sr[0] ^ r_b_sr[0] ^ r_bw;
  assign w_bw_nxt  = (~r_a_sr[0] & r_b_sr[0]) | (~(r_a_sr[0] ^ r_b_sr[0]) & r_bw);
  // New bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
  assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};
  assign w_last    = (r_state == S_RUN) && (r_cnt == CW'(WIDTH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start)  w_state_nxt = S_RUN;
      S_RUN:  if (w_last) w_state_nxt = S_IDLE;
      default:            w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_bw     <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start) begin
          r_a_sr <= a;
          r_b_sr <= b;
          r_res  <= '0;
          r_cnt  <= '0;
          r_bw   <= 1'b0;
        end
      end else begin
        r_a_sr <= r_a_sr >> 1;
        r_b_sr <= r_b_sr >> 1;
        r_res  <= w_res_nxt;
        r_bw   <= w_bw_nxt;
        r_cnt  <= r_cnt + 1'b1;
        if (w_last) begin
          r_done   <= 1'b1;
          r_borrow <= w_bw_nxt;
          r_diff   <= (SATURATE && w_bw_nxt) ? '0 : w_res_nxt;
        end
      end
    end
  end

  assign busy   = (r_state == S_RUN);
  assign done   = r_done;
  assign diff   = r_diff;
  assign borrow = r_borrow;

endmodule
